// File: rtl/tt_mask_idx_arb.sv
// tt_mask_idx_arb
// Two-requester, burst-aware round-robin arbiter feeding one credited downstream channel.
// Once a requester wins with last=0 it owns the channel until it sends an item with last=1.
// Downstream outputs are registered, so each accepted item appears one cycle after its
// ready/valid handshake.
//
// Ports:
//   i_clk, i_reset_n                     clock, async active-low reset
//   i_reqN_valid/item/last, o_reqN_ready requester N handshake (ready is combinational)
//   i_mask_idx_credit                    one-cycle pulse returning one downstream credit
//   i_flush                              synchronous abort of the current burst
//   o_mask_idx_valid/item/last_idx/src   registered downstream channel
//   o_credits                            current credit count
//   o_busy                               high while a burst owns the channel
//   o_credit_err                         sticky credit-overflow flag
module tt_mask_idx_arb #(
  parameter int unsigned MASK_CREDITS = 2,
  localparam int unsigned CW = $clog2(MASK_CREDITS + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_req0_valid,
  input  logic [64:0]   i_req0_item,
  input  logic          i_req0_last,
  output logic          o_req0_ready,
  input  logic          i_req1_valid,
  input  logic [64:0]   i_req1_item,
  input  logic          i_req1_last,
  output logic          o_req1_ready,
  input  logic          i_mask_idx_credit,
  input  logic          i_flush,
  output logic          o_mask_idx_valid,
  output logic [64:0]   o_mask_idx_item,
  output logic          o_mask_idx_last_idx,
  output logic          o_mask_idx_src,
  output logic [CW-1:0] o_credits,
  output logic          o_busy,
  output logic          o_credit_err
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;

  logic          out_valid_q;
  logic [64:0]   out_item_q;
  logic          out_last_q;
  logic          out_src_q;

  logic [CW:0]   avail;
  logic [CW:0]   next_cnt;
  logic          cand;
  logic          cand_valid;
  logic          cand_last;
  logic          fire;

  // A credit returned this cycle can be spent this cycle.
  assign avail = {1'b0, credits_q} + {{CW{1'b0}}, i_mask_idx_credit};

  // Candidate selection: the owner during a burst, otherwise the sole valid requester
  // or, on contention, the one rr points at.
  always_comb begin
    cand = 1'b0;
    if (state_q == StBurst) begin
      cand = owner_q;
    end else if (i_req0_valid && i_req1_valid) begin
      cand = rr_q;
    end else begin
      cand = i_req1_valid;
    end
    cand_valid = cand ? i_req1_valid : i_req0_valid;
    cand_last  = cand ? i_req1_last  : i_req0_last;
    // Gating with i_reset_n keeps both readies low while reset is held.
    fire = cand_valid && (avail != '0) && !i_flush && i_reset_n;
    o_req0_ready = fire && !cand;
    o_req1_ready = fire && cand;
  end

  // Credit counter with saturation at MASK_CREDITS on overflow.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    next_cnt  = avail - {{CW{1'b0}}, fire};
    if (next_cnt > (CW + 1)'(MASK_CREDITS)) begin
      credits_d = CW'(MASK_CREDITS);
      err_d     = 1'b1;
    end else begin
      credits_d = next_cnt[CW-1:0];
    end
  end

  // FSM / owner / round-robin pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (i_flush) begin
      state_d = StIdle;
      rr_d    = 1'b0;
    end else if (fire) begin
      unique case (state_q)
        StIdle: begin
          rr_d = ~cand;
          if (!cand_last) begin
            state_d = StBurst;
            owner_d = cand;
          end
        end
        StBurst: begin
          if (cand_last) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      credits_q <= CW'(MASK_CREDITS);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Downstream register: valid follows fire; payload holds when nothing fires.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_valid_q <= 1'b0;
      out_item_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= fire;
      if (fire) begin
        out_item_q <= cand ? i_req1_item : i_req0_item;
        out_last_q <= cand_last;
        out_src_q  <= cand;
      end
    end
  end

  assign o_mask_idx_valid    = out_valid_q;
  assign o_mask_idx_item     = out_item_q;
  assign o_mask_idx_last_idx = out_last_q;
  assign o_mask_idx_src      = out_src_q;
  assign o_credits           = credits_q;
  assign o_busy              = (state_q == StBurst);
  assign o_credit_err        = err_q;

endmodule

// File: doc/tt_mask_idx_arb.md
TT_MASK_IDX_ARB -- requirements
Module: tt_mask_idx_arb

Interface
REQ-001 SHALL have parameter MASK_CREDITS, default 2, meaning the number of downstream item buffers available to the channel (1..7).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have ports i_req0_valid / i_req1_valid, input, 1, meaning the requester offers an item.
REQ-005 SHALL have ports i_req0_item / i_req1_item, input, 65, meaning the item payload.
REQ-006 SHALL have ports i_req0_last / i_req1_last, input, 1, meaning the offered item ends the requester's burst.
REQ-007 SHALL have ports o_req0_ready / o_req1_ready, output, 1, meaning the item is accepted this cycle (combinational).
REQ-008 SHALL have port i_mask_idx_credit, input, 1, meaning a one-cycle pulse returning one credit.
REQ-009 SHALL have port i_flush, input, 1, meaning a synchronous abort of the current burst.
REQ-010 SHALL have output ports o_mask_idx_valid (1), o_mask_idx_item (65), o_mask_idx_last_idx (1) and o_mask_idx_src (1, the winning requester index), all driving the credited downstream channel.
REQ-011 SHALL have port o_credits, output, $clog2(MASK_CREDITS+1), meaning the current credit count.
REQ-012 SHALL have port o_busy, output, 1, meaning the FSM is in BURST.
REQ-013 SHALL have port o_credit_err, output, 1, a sticky flag set on credit overflow.

Function
REQ-014 SHALL keep the credit counter with avail = credits + i_mask_idx_credit, and next = avail - fire, where fire is any ready&valid.
REQ-015 SHALL accept an item only when avail > 0, so a credit returned in a given cycle is usable in that same cycle.
REQ-016 SHALL handle a return that would exceed MASK_CREDITS by holding the counter at MASK_CREDITS and setting o_credit_err, which stays set until reset.
REQ-017 SHALL run an FSM with states IDLE and BURST, plus a locked-owner register and a round-robin pointer rr.
REQ-018 IDLE: when exactly one requester is valid, it SHALL be the candidate; when both are valid, the requester selected by rr SHALL be the candidate.
REQ-019 IDLE: when the candidate fires, rr SHALL point to the other requester; if the fired item has last=0, the FSM SHALL move to BURST with owner = candidate; if last=1, it SHALL stay in IDLE.
REQ-020 BURST: only the owner SHALL be eligible; the other requester's ready SHALL be 0 regardless of its valid.
REQ-021 BURST: when an owner item with last=1 fires, the FSM SHALL return to IDLE.
REQ-022 SHALL never assert a ready when the matching valid is 0, and SHALL assert at most one ready per cycle.
REQ-023 SHALL register the downstream outputs with exactly one cycle of latency: o_mask_idx_valid = fire of the previous cycle, with item, last_idx and src captured from the fired requester.
REQ-024 SHALL set o_mask_idx_valid=0 in any cycle following a cycle with no fire; item/last_idx/src SHALL then hold their previous values.
REQ-025 i_flush: FSM SHALL go to IDLE and rr to requester 0, both ready outputs SHALL be 0 in the flush cycle, the credit counter SHALL still absorb i_mask_idx_credit, and an output already registered SHALL still be presented.
REQ-026 SHALL report o_busy = (state == BURST) and o_credits = the registered credit count.

Reset
REQ-027 On i_reset_n=0 (asynchronous), all of the following SHALL hold: state=IDLE, rr=0, owner=0, credits=MASK_CREDITS, o_mask_idx_valid=0, o_mask_idx_item=0, o_mask_idx_last_idx=0, o_mask_idx_src=0, o_credit_err=0.
REQ-028 Ready outputs SHALL be 0 while reset is asserted.
REQ-029 Reset asserted mid-burst SHALL discard the burst with no further output.
REQ-030 After reset release, the first eligible edge SHALL behave exactly as IDLE with full credits.

Verification
REQ-031 Both requesters valid, last=1 each cycle, credits returned every cycle -> grants alternate 0,1,0,1 and o_mask_idx_src alternates one cycle later.
REQ-032 req0 sends a 4-item burst (last on item 4) while req1 is valid throughout -> req1 ready=0 until the cycle after req0's last fires, then req1 is granted.
REQ-033 MASK_CREDITS=2 with no credit returns, req0 streaming -> exactly 2 fires, then ready=0 and o_credits=0; a credit pulse -> one fire in that same cycle.
REQ-034 Credit pulse while o_credits=2 (MASK_CREDITS=2) and idle -> o_credits stays 2 and o_credit_err=1 persists until reset.
REQ-035 i_flush during the 2nd beat of a req1 burst -> no ready that cycle, o_busy=0 next cycle; a fire in the flush-1 cycle still appears on the output.
REQ-036 Async reset pulse mid-burst between clock edges -> outputs go to 0 immediately, and o_credits=MASK_CREDITS.
